scan_io_memory_bank: RTL



---
 rtl/scan_io_mem_pkg.sv | 23 ++
 rtl/scan_io_memory_bank_scan_reg.sv | 37 +++
 rtl/scan_io_memory_bank.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/scan_io_mem_pkg.sv
// Shared constants for the scan-chained memory bank with IO window.
// IO offsets, seven-segment digit table and the unmapped-read value.
package scan_io_mem_pkg;

  localparam int OFS_IO     = 0;
  localparam int OFS_FLAGS  = 1;
  localparam int OFS_BASE   = 2;
  localparam int OFS_DIGIT0 = 3;
  localparam int NUM_DIGITS = 10;

  // Digits 9..0, so index i selects digit i ({seg[6:0],1'b0}).
  localparam logic [NUM_DIGITS-1:0][7:0] DIGIT_ROM = {
    8'hCE, 8'hFE, 8'h0E, 8'hF8, 8'hDA,
    8'hCC, 8'h9E, 8'hB6, 8'h0C, 8'h7E
  };

  localparam logic [7:0] DEFAULT_READ = 8'h01;

  function automatic logic [7:0] seg_digit(input logic [3:0] i);
    return DIGIT_ROM[i];
  endfunction

endpackage

// File: rtl/scan_io_memory_bank_scan_reg.sv
// One scan-chain register: async reset, functional load, scan shift.
// Ports: clk, rst_n, scan_enable, scan_in, load, d -> q, scan_out.
module scan_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scan_enable,
  input  logic             scan_in,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             scan_out
);

  logic [WIDTH-1:0] shifted;

  // Bit 0 receives the incoming bit, bit WIDTH-1 leaves the register.
  if (WIDTH == 1) begin : g_one
    assign shifted = scan_in;
  end else begin : g_many
    assign shifted = {q[WIDTH-2:0], scan_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (scan_enable) begin
      q <= shifted;
    end else if (load) begin
      q <= d;
    end
  end

  assign scan_out = q[WIDTH-1];

endmodule

// File: rtl/scan_io_memory_bank.sv
// Scan-chained memory bank with LED, button capture, digit ROM and key.
// Optional macro BTN_DEBOUNCE_EN adds per-button debounce counters.
module scan_io_memory_bank
  import scan_io_mem_pkg::*;
#(
  parameter int ADDR_WIDTH      = 5,
  parameter int DATA_WIDTH      = 8,
  parameter int MEM_SIZE        = 15,
  parameter int NUM_BTN         = 2,
  parameter int KEY_WIDTH       = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  scan_enable,
  input  logic                  scan_in,
  output logic                  scan_out,
  input  logic [NUM_BTN-1:0]    btn_in,
  output logic [DATA_WIDTH-2:0] led_out,
  output logic [KEY_WIDTH-1:0]  locking_key,
  output logic                  btn_irq
);

  localparam int IO_ADDR = MEM_SIZE;
  localparam int LW      = DATA_WIDTH - 1;

  localparam logic [ADDR_WIDTH-1:0] A_IO =
    ADDR_WIDTH'(IO_ADDR + OFS_IO);
  localparam logic [ADDR_WIDTH-1:0] A_FLG =
    ADDR_WIDTH'(IO_ADDR + OFS_FLAGS);
  localparam logic [ADDR_WIDTH-1:0] A_BASE =
    ADDR_WIDTH'(IO_ADDR + OFS_BASE);
  localparam logic [ADDR_WIDTH-1:0] A_D0 =
    ADDR_WIDTH'(IO_ADDR + OFS_DIGIT0);
  localparam logic [ADDR_WIDTH-1:0] A_D9 =
    ADDR_WIDTH'(IO_ADDR + OFS_DIGIT0 + NUM_DIGITS - 1);

  if (MEM_SIZE + 13 > (1 << ADDR_WIDTH)) begin : g_bad_addr
    $error("ADDR_WIDTH too small for MEM_SIZE");
  end
  if (NUM_BTN < 1 || NUM_BTN > DATA_WIDTH - 1) begin : g_bad_btn
    $error("NUM_BTN out of range");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be >= 1");
  end

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
  logic [MEM_SIZE:0]     mem_so;
  logic [LW-1:0]         led_q;
  logic                  led_so;
  logic [NUM_BTN-1:0]    flags_q;
  logic [NUM_BTN-1:0]    flags_d;
  logic [NUM_BTN-1:0]    flags_clr;
  logic                  flags_so;
  logic [KEY_WIDTH-1:0]  key_q;

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] prev;
  logic [NUM_BTN-1:0] rise;

  assign mem_so[0] = scan_in;

  for (genvar i = 0; i < MEM_SIZE; i++) begin : g_mem
    logic ld;
    assign ld = write_enable && (address == ADDR_WIDTH'(i));
    scan_reg #(.WIDTH(DATA_WIDTH)) u_word (
      .clk        (clk),
      .rst_n      (rst_n),
      .scan_enable(scan_enable),
      .scan_in    (mem_so[i]),
      .load       (ld),
      .d          (data_in),
      .q          (mem_q[i]),
      .scan_out   (mem_so[i+1])
    );
  end

  scan_reg #(.WIDTH(LW)) u_led (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_enable(scan_enable),
    .scan_in    (mem_so[MEM_SIZE]),
    .load       (write_enable && (address == A_IO)),
    .d          (data_in[DATA_WIDTH-1:1]),
    .q          (led_q),
    .scan_out   (led_so)
  );

  // Set wins over a simultaneous write-1-to-clear of the same bit.
  assign flags_clr = (write_enable && (address == A_FLG))
                   ? data_in[NUM_BTN-1:0] : '0;
  assign flags_d   = (flags_q & ~flags_clr) | rise;

  scan_reg #(.WIDTH(NUM_BTN)) u_flags (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_enable(scan_enable),
    .scan_in    (led_so),
    .load       (1'b1),
    .d          (flags_d),
    .q          (flags_q),
    .scan_out   (flags_so)
  );

  scan_reg #(.WIDTH(KEY_WIDTH)) u_key (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_enable(scan_enable),
    .scan_in    (flags_so),
    .load       (1'b0),
    .d          ('0),
    .q          (key_q),
    .scan_out   (scan_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      prev  <= level;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt [NUM_BTN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync2[i] != level[i]) begin
          if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            level[i] <= sync2[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign level = sync2;
`endif

  assign rise = level & ~prev;

  logic                  is_mem;
  logic                  is_dig;
  logic [3:0]            dig_idx;
  logic [DATA_WIDTH-1:0] rdata;

  assign is_mem  = address < ADDR_WIDTH'(MEM_SIZE);
  assign is_dig  = (address >= A_D0) && (address <= A_D9);
  assign dig_idx = 4'(address - A_D0);

  always_comb begin
    rdata = DATA_WIDTH'(DEFAULT_READ);
    unique case (1'b1)
      is_mem: begin
        for (int i = 0; i < MEM_SIZE; i++) begin
          if (address == ADDR_WIDTH'(i)) rdata = mem_q[i];
        end
      end
      address == A_IO:   rdata = {led_q, level[0]};
      address == A_FLG:  rdata = DATA_WIDTH'(flags_q);
      address == A_BASE: rdata = DATA_WIDTH'(IO_ADDR + OFS_DIGIT0);
      is_dig:            rdata = DATA_WIDTH'(seg_digit(dig_idx));
      default:           ;
    endcase
  end

  assign data_out    = rdata;
  assign led_out     = led_q;
  assign locking_key = key_q;
  assign btn_irq     = |flags_q;

endmodule
